// File: rtl/apb4_regbank_slave.sv
`timescale 1ns/1ps
// APB4 completer over a bank of NUM_REGS registers with wait states, byte strobes and PSLVERR.
// Optional feature: define APB_PROT_CHECK_EN to reject non-secure accesses to SEC_MASK registers.
module apb4_regbank_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS-1:0] SEC_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  input  logic [2:0]                 pprot,
  output logic                       pready,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] ro_in,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] BANK_BYTES = ADDR_W'(NUM_REGS * STRB_W);
  localparam logic [ADDR_W-1:0] LSB_MASK = ADDR_W'(STRB_W - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                             state;
  logic [3:0]                         wait_cnt;
  logic [NUM_REGS-1:0][DATA_W-1:0]    mem;
  logic [IDX_W-1:0]                   idx_q;
  logic                               pwrite_q;
  logic [STRB_W-1:0]                  pstrb_q;
  logic [DATA_W-1:0]                  pwdata_q;
  logic [2:0]                         pprot_q;
  logic                               err_q;

  logic [ADDR_W-1:0]                  offset;
  logic [IDX_W-1:0]                   idx_c;
  logic                               err_c;
  logic                               unused_ok;

  assign reg_out = mem;
  assign unused_ok = ^{pprot_q, SEC_MASK};

  // Decode and fault detection from the live setup-phase bus values.
  always_comb begin
    offset = paddr - BASE_ADDR;
    idx_c  = IDX_W'(offset >> LSB_W);
    err_c  = (offset >= BANK_BYTES) || ((offset & LSB_MASK) != '0);
    if (!err_c && pwrite && RO_MASK[idx_c]) err_c = 1'b1;
`ifdef APB_PROT_CHECK_EN
    if (!err_c && pprot[1] && SEC_MASK[idx_c]) err_c = 1'b1;
`endif
  end

  function automatic logic [DATA_W-1:0] read_val(input logic [IDX_W-1:0] i);
    read_val = RO_MASK[i] ? ro_in[i*DATA_W +: DATA_W] : mem[i];
  endfunction

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state    <= IDLE;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      wr_pulse <= '0;
      mem      <= RST_VAL;
      wait_cnt <= '0;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      pprot_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_pulse <= '0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (psel && !penable) begin
            state    <= ACCESS;
            idx_q    <= idx_c;
            pwrite_q <= pwrite;
            pstrb_q  <= pstrb;
            pwdata_q <= pwdata;
            pprot_q  <= pprot;
            err_q    <= err_c;
            wait_cnt <= 4'(WAIT_STATES);
            // Zero wait states: response is ready for the very first access cycle.
            if (WAIT_STATES == 0) begin
              pready  <= 1'b1;
              pslverr <= err_c;
              prdata  <= (!err_c && !pwrite) ? read_val(idx_c) : '0;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end else if (penable && pready) begin
            if (pwrite_q && !err_q && (pstrb_q != '0)) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (pstrb_q[b]) mem[idx_q][b*8 +: 8] <= pwdata_q[b*8 +: 8];
              end
              wr_pulse[idx_q] <= 1'b1;
            end
            state   <= DONE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end else begin
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            // Read data is sampled here so RO inputs may move during wait states.
            if (wait_cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= err_q;
              prdata  <= (!err_q && !pwrite_q) ? read_val(idx_q) : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_regbank_slave.sv
`timescale 1ns/1ps
// Scoreboard bench for apb4_regbank_slave: one instance with 0 wait states, one with 3.
// Expected responses come from a register model and are queued when each transfer is launched.
module tb_apb4_regbank_slave;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam logic [15:0] RO0 = 16'h0001;
  localparam logic [15:0] RO3 = 16'h0000;
  localparam logic [15:0] SEC = 16'h0008;
`ifdef APB_PROT_CHECK_EN
  localparam bit PROT_CHK = 1'b1;
`else
  localparam bit PROT_CHK = 1'b0;
`endif

  function automatic logic [31:0] rst_word(input int i);
    return {16'hC0DE, 16'(i)};
  endfunction

  function automatic logic [NR*DW-1:0] build_rst();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = rst_word(i);
    return v;
  endfunction

  localparam logic [NR*DW-1:0] RST_IMG = build_rst();

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [2:0] pprot = '0;
  logic [NR*DW-1:0] ro_in, reg_out0, reg_out3;
  logic pready0, pready3, pslverr0, pslverr3;
  logic [31:0] prdata0, prdata3;
  logic [15:0] wr_pulse0, wr_pulse3;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [15:0] pulse;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  logic [31:0] model [2][NR];
  int tests = 0;
  int failures = 0;
  time setup_t = 0;

  apb4_regbank_slave #(.WAIT_STATES(0), .RO_MASK(RO0), .SEC_MASK(SEC), .RST_VAL(RST_IMG)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready0),
    .prdata(prdata0), .pslverr(pslverr0), .reg_out(reg_out0), .ro_in(ro_in), .wr_pulse(wr_pulse0));

  apb4_regbank_slave #(.WAIT_STATES(3), .RO_MASK(RO3), .SEC_MASK(SEC), .RST_VAL(RST_IMG)) dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready3),
    .prdata(prdata3), .pslverr(pslverr3), .reg_out(reg_out3), .ro_in(ro_in), .wr_pulse(wr_pulse3));

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] model_flat(input int d);
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[d][i];
    return v;
  endfunction

  function automatic logic ready_of(input int d);
    return (d == 3) ? pready3 : pready0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NR; i++) begin
      model[0][i] = rst_word(i);
      model[1][i] = rst_word(i);
    end
  endtask

  // d selects the instance: 0 -> no wait states, 3 -> three wait states
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
    exp_t e;
    int m, idx, lat;
    logic ro_bit, rdy;
    m = (d == 3) ? 1 : 0;
    idx = int'(addr[5:2]);
    ro_bit = (d == 3) ? RO3[idx] : RO0[idx];
    e.err = (addr >= 32'd64) || (addr[1:0] != 2'b00) || (wr && ro_bit) ||
            (PROT_CHK && prot[1] && SEC[idx]);
    e.rdata = (!e.err && !wr) ? (ro_bit ? ro_in[idx*DW +: DW] : model[m][idx]) : 32'h0;
    e.pulse = (!e.err && wr && strb != 4'h0) ? (16'h0001 << idx) : 16'h0000;
    e.lat = (d == 3) ? 8'd4 : 8'd1;
    if (!e.err && wr) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[m][idx][b*8 +: 8] = data[b*8 +: 8];
    end
    sb.push_back(e);

    @(negedge pclk);
    setup_t = $time;
    psel0 = (d != 3); psel3 = (d == 3); penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
    @(negedge pclk);
    penable = 1'b1;
    lat = 1;
    rdy = ready_of(d);
    while (!rdy && lat < 40) begin
      @(negedge pclk);
      lat++;
      rdy = ready_of(d);
    end
    e = sb.pop_front();
    if (!rdy) begin
      checkOutput("pready_timeout", 0, 1);
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
      return;
    end
    checkOutput("latency", lat, e.lat);
    checkOutput("pslverr", (d == 3) ? pslverr3 : pslverr0, e.err);
    checkOutput("prdata", (d == 3) ? prdata3 : prdata0, e.rdata);
    @(posedge pclk);
    #1;
    checkOutput("wr_pulse", (d == 3) ? wr_pulse3 : wr_pulse0, e.pulse);
    checkOutput("pready_after", ready_of(d), 0);
    checkOutput("reg_out", (d == 3) ? reg_out3 : reg_out0, model_flat(m));
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    time prev_t;
    for (int i = 0; i < NR; i++) ro_in[i*DW +: DW] = 32'hF00D_0000 | 32'(i);
    resetModel();

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("rst_pready", {pready0, pready3}, 2'b00);
    checkOutput("rst_pslverr", {pslverr0, pslverr3}, 2'b00);
    checkOutput("rst_prdata", {prdata0, prdata3}, 64'h0);
    checkOutput("rst_wr_pulse", {wr_pulse0, wr_pulse3}, 32'h0);
    checkOutput("rst_reg_out0", reg_out0, RST_IMG);
    checkOutput("rst_reg_out3", reg_out3, RST_IMG);
    @(negedge pclk);
    presetn = 1'b1;

    // Zero-wait write/read, byte lanes, empty strobe
    applyStimulus(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000);
    @(posedge pclk); #1;
    checkOutput("pulse_clear", wr_pulse0, 16'h0);
    applyStimulus(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000);
    applyStimulus(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 3'b000);
    applyStimulus(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 3'b000);
    applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'hF, 3'b000);
    applyStimulus(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 3'b000);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);

    // Faults and RO read
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    applyStimulus(0, 1'b1, 32'h6, 32'h12345678, 4'hF, 3'b000);
    applyStimulus(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 3'b000);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    applyStimulus(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000);

    // Secure region
    applyStimulus(0, 1'b1, 32'hC, 32'hCAFEF00D, 4'hF, 3'b010);
    applyStimulus(0, 1'b0, 32'hC, 32'h0, 4'h0, 3'b000);
    applyStimulus(0, 1'b1, 32'hC, 32'h0BADC0DE, 4'hF, 3'b000);
    applyStimulus(0, 1'b0, 32'hC, 32'h0, 4'h0, 3'b010);

    // Three wait states: read latency, back-to-back writes, read back, fault
    applyStimulus(3, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000);
    prev_t = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3, 1'b1, 32'h10 + 32'(4*i), 32'h1000_0001 * 32'(i + 1), 4'hF, 3'b000);
      if (i > 0) checkOutput("b2b_period", 64'(setup_t - prev_t), 64'd50);
      prev_t = setup_t;
    end
    for (int i = 0; i < 4; i++) applyStimulus(3, 1'b0, 32'h10 + 32'(4*i), 32'h0, 4'h0, 3'b000);
    applyStimulus(3, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000);

    // psel dropped during wait states
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h77777777; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel3 = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(posedge pclk); #1;
      checkOutput("drop_pready", pready3, 0);
      checkOutput("drop_wr_pulse", wr_pulse3, 16'h0);
    end
    checkOutput("drop_reg_out", reg_out3, model_flat(1));
    applyStimulus(3, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);

    // Reset during the access phase of a write
    @(negedge pclk);
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h12345678; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    @(posedge pclk); #1;
    resetModel();
    checkOutput("midrst_pready", pready3, 0);
    checkOutput("midrst_reg_out", reg_out3, RST_IMG);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    applyStimulus(3, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
